// File: rtl/rst_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : rst_seq_if
// Brief    : Request/enable/hold inputs and domain-reset/cause outputs of rst_seq.
// Revision : 1.0 - initial release
// ============================================================================
interface rst_seq_if #(
  parameter int SRC_NUM = 4,
  parameter int DOM_NUM = 3,
  parameter int CNT_W   = 4
);
  logic [SRC_NUM-1:0] src_rst_req;
  logic [SRC_NUM-1:0] src_en;
  logic [CNT_W-1:0]   hold_cycles;
  logic               cause_clr;
  logic [DOM_NUM-1:0] dom_rst_n;
  logic               rst_busy;
  logic [SRC_NUM-1:0] cause;

  modport master (
    output src_rst_req, src_en, hold_cycles, cause_clr,
    input  dom_rst_n, rst_busy, cause
  );

  modport slave (
    input  src_rst_req, src_en, hold_cycles, cause_clr,
    output dom_rst_n, rst_busy, cause
  );
endinterface
`default_nettype wire

// File: rtl/rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : rst_seq
// Brief    : Merges maskable reset requests, holds all domains, then releases
//            them in order with a fixed stagger; keeps a sticky cause record.
// Revision : 1.0 - initial release
// ============================================================================
module rst_seq #(
  parameter int                 SRC_NUM     = 4,
  parameter int                 DOM_NUM     = 3,
  parameter int                 CNT_W       = 4,
  parameter int                 STAGGER     = 2,
  parameter int                 SYNC_STAGES = 2,
  parameter logic [SRC_NUM-1:0] ASYNC_MASK  = SRC_NUM'(1)
) (
  input  wire logic  clk,
  input  wire logic  rst,
  rst_seq_if.slave   bus
);

  localparam int                 IDX_W       = $clog2(DOM_NUM + 1);
  localparam logic [CNT_W-1:0]   c_stag_last = CNT_W'(STAGGER - 1);
  localparam logic [IDX_W-1:0]   c_idx_last  = IDX_W'(DOM_NUM - 1);

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_REL  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DOM_NUM-1:0] dom_q, dom_d;
  logic               busy_q, busy_d;
  logic [SRC_NUM-1:0] cause_q, cause_d;

  logic [SRC_NUM-1:0] req_s;
  logic [SRC_NUM-1:0] req_seen;
  logic               req_eff;

  genvar gi;
  generate
    for (gi = 0; gi < SRC_NUM; gi++) begin : g_src
      if (ASYNC_MASK[gi]) begin : g_async
        logic [SYNC_STAGES-1:0] sync_q, sync_d;

        always_comb sync_d = {sync_q[SYNC_STAGES-2:0], bus.src_rst_req[gi]};

        always_ff @(posedge clk) begin
          if (rst) sync_q <= '0;
          else     sync_q <= sync_d;
        end

        assign req_s[gi] = sync_q[SYNC_STAGES-1];
      end else begin : g_direct
        assign req_s[gi] = bus.src_rst_req[gi];
      end
    end
  endgenerate

  assign req_seen = req_s & bus.src_en;
  assign req_eff  = |req_seen;

  // A fresh set beats a same-cycle clear for that bit.
  always_comb cause_d = (bus.cause_clr ? '0 : cause_q) | req_seen;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dom_d   = dom_q;
    busy_d  = busy_q;
    if (req_eff) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      dom_d   = '0;
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        ST_HOLD: begin
          // >= so that shrinking hold_cycles mid-hold releases immediately
          if (cnt_q >= bus.hold_cycles) begin
            dom_d[0] = 1'b1;
            cnt_d    = '0;
            if (DOM_NUM == 1) begin
              state_d = ST_RUN;
              busy_d  = 1'b0;
            end else begin
              state_d = ST_REL;
              idx_d   = IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_REL: begin
          if (cnt_q == c_stag_last) begin
            for (int k = 0; k < DOM_NUM; k++) begin
              if (IDX_W'(k) == idx_q) dom_d[k] = 1'b1;
            end
            cnt_d = '0;
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == c_idx_last) begin
              state_d = ST_RUN;
              busy_d  = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          dom_d  = '1;
          busy_d = 1'b0;
        end
        default: begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          idx_d   = '0;
          dom_d   = '0;
          busy_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      dom_q   <= '0;
      busy_q  <= 1'b1;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dom_q   <= dom_d;
      busy_q  <= busy_d;
      cause_q <= cause_d;
    end
  end

  assign bus.dom_rst_n = dom_q;
  assign bus.rst_busy  = busy_q;
  assign bus.cause     = cause_q;

endmodule
`default_nettype wire
